// File: rtl/pipeline_pkg.sv
// Shared MEM-stage definitions: controller state encoding and default widths.
package pipeline_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_RADDR_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// Request/acknowledge data-memory bus between the MEM-stage controller (master) and dmem (slave).
interface mem_stage_dmem_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dmem_watchdog.sv
// WAIT-state cycle counter for the dmem access; expire marks the last permitted wait cycle.
// Only compiled when DMEM_TIMEOUT_EN is defined.
`ifdef DMEM_TIMEOUT_EN
module dmem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = enable && (cnt == CNT_W'(TIMEOUT - 1));
endmodule
`endif

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage controller: issues loads/stores on a req/ack dmem bus, stalls upstream, drives MEM/WB.
// Optional DMEM_TIMEOUT_EN adds a WAIT watchdog that aborts the access and sets sticky dmem_err.
module mem_stage_dmem_ctrl
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic [DATA_W-1:0]      rt_data,
    input  logic [RADDR_W-1:0]     rd_addr,
    input  logic                   mem_w,
    input  logic                   mem_r,
    input  logic                   mem2reg,
    input  logic                   reg_write,
    output logic                   stall,
    mem_stage_dmem_ctrl_if.master  dmem,
    output logic [DATA_W-1:0]      wb_data,
    output logic [RADDR_W-1:0]     wb_rd_addr,
    output logic                   wb_reg_write,
    output logic                   wb_valid,
    output logic                   dmem_err
);
    mem_state_t state, state_nxt;

    logic               access;
    logic               timeout_hit;
    logic               capture, retire_alu, retire_mem, abort;
    logic [RADDR_W-1:0] cap_rd_addr;
    logic               cap_mem2reg;
    logic               cap_reg_write;

    assign access = mem_r | mem_w;

`ifdef DMEM_TIMEOUT_EN
    dmem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_IDLE),
        .enable (state == ST_WAIT),
        .expire (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_err <= 1'b0;
        end else if (abort) begin
            dmem_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign dmem_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (access) state_nxt = ST_WAIT;
            ST_WAIT: if (dmem.ack || timeout_hit) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // An acknowledge on the timeout cycle takes priority over the abort.
    always_comb begin
        capture    = 1'b0;
        retire_alu = 1'b0;
        retire_mem = 1'b0;
        abort      = 1'b0;
        stall      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    capture = 1'b1;
                    stall   = 1'b1;
                end else begin
                    retire_alu = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem.ack)        retire_mem = 1'b1;
                else if (timeout_hit) abort     = 1'b1;
                else                  stall     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.req      <= 1'b0;
            dmem.we       <= 1'b0;
            dmem.addr     <= '0;
            dmem.wdata    <= '0;
            cap_rd_addr   <= '0;
            cap_mem2reg   <= 1'b0;
            cap_reg_write <= 1'b0;
        end else if (capture) begin
            dmem.req      <= 1'b1;
            dmem.we       <= mem_w;
            dmem.addr     <= alu_result;
            dmem.wdata    <= rt_data;
            cap_rd_addr   <= rd_addr;
            cap_mem2reg   <= mem2reg;
            cap_reg_write <= reg_write;
        end else if (retire_mem || abort) begin
            dmem.req      <= 1'b0;
        end
    end

    // Anything that does not retire this cycle becomes a WB bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data      <= '0;
            wb_rd_addr   <= '0;
            wb_reg_write <= 1'b0;
            wb_valid     <= 1'b0;
        end else begin
            wb_valid     <= retire_alu | retire_mem | abort;
            wb_reg_write <= 1'b0;
            if (retire_alu) begin
                wb_data      <= alu_result;
                wb_rd_addr   <= rd_addr;
                wb_reg_write <= reg_write;
            end else if (retire_mem) begin
                wb_data      <= cap_mem2reg ? dmem.rdata : dmem.addr;
                wb_rd_addr   <= cap_rd_addr;
                wb_reg_write <= cap_reg_write;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed bench for mem_stage_dmem_ctrl with a transaction-level reference model.
// Timeout scenarios run only when DMEM_TIMEOUT_EN is defined.
module tb_mem_stage_dmem_ctrl;
    localparam int TIMEOUT = 4;
`ifdef DMEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] rt_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        mem_w = 1'b0, mem_r = 1'b0, mem2reg = 1'b0, reg_write = 1'b0;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write, wb_valid, dmem_err;

    mem_stage_dmem_ctrl_if #(.DATA_W(32)) dmem_bus ();

    mem_stage_dmem_ctrl #(.DATA_W(32), .RADDR_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_result   (alu_result),
        .rt_data      (rt_data),
        .rd_addr      (rd_addr),
        .mem_w        (mem_w),
        .mem_r        (mem_r),
        .mem2reg      (mem2reg),
        .reg_write    (reg_write),
        .stall        (stall),
        .dmem         (dmem_bus),
        .wb_data      (wb_data),
        .wb_rd_addr   (wb_rd_addr),
        .wb_reg_write (wb_reg_write),
        .wb_valid     (wb_valid),
        .dmem_err     (dmem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // Reference model: one outstanding transaction plus the expected registered outputs.
    bit          m_busy = 0;
    int          m_wait = 0;
    bit          m_m2r = 0, m_rw = 0;
    logic [4:0]  m_rd = '0;
    logic        m_req = 0, m_we = 0, m_err = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [31:0] e_data = '0;
    logic [4:0]  e_rd = '0;
    logic        e_rw = 0, e_valid = 0;

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_req = 0; m_we = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_rd = '0; m_m2r = 0; m_rw = 0;
        e_data = '0; e_rd = '0; e_rw = 0; e_valid = 0;
    endtask

    function automatic bit model_timeout_now();
        return TO_EN && m_busy && (m_wait == TIMEOUT - 1);
    endfunction

    task automatic model_step();
        e_valid = 0;
        e_rw    = 0;
        if (!m_busy) begin
            if (mem_r || mem_w) begin
                m_busy = 1; m_wait = 0; m_req = 1; m_we = mem_w;
                m_addr = alu_result; m_wdata = rt_data;
                m_rd = rd_addr; m_m2r = mem2reg; m_rw = reg_write;
            end else begin
                e_data = alu_result; e_rd = rd_addr; e_rw = reg_write; e_valid = 1;
            end
        end else if (dmem_bus.ack) begin
            m_busy = 0; m_req = 0;
            e_data = m_m2r ? dmem_bus.rdata : m_addr;
            e_rd = m_rd; e_rw = m_rw; e_valid = 1;
        end else if (model_timeout_now()) begin
            m_busy = 0; m_req = 0; m_err = 1; e_valid = 1;
        end else begin
            m_wait++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Continuous comparison against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("stall", stall,
                m_busy ? !(dmem_bus.ack || model_timeout_now()) : (mem_r || mem_w));
            chk("dmem_req", dmem_bus.req, m_req);
            chk("dmem_we", dmem_bus.we, m_we);
            chk("dmem_addr", dmem_bus.addr, m_addr);
            chk("dmem_wdata", dmem_bus.wdata, m_wdata);
            chk("wb_valid", wb_valid, e_valid);
            chk("wb_reg_write", wb_reg_write, e_rw);
            chk("wb_data", wb_data, e_data);
            chk("wb_rd_addr", wb_rd_addr, e_rd);
            chk("dmem_err", dmem_err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        alu_result = '0; rt_data = '0; rd_addr = '0;
        mem_w = 0; mem_r = 0; mem2reg = 0; reg_write = 0;
    endtask

    // Present one memory op, ack it on WAIT cycle ack_after+1, return stall cycles and latency.
    task automatic run_mem(input logic st, input logic ld, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input logic m2r,
                           input logic rw, input int ack_after, input logic [31:0] rdata,
                           output int stalls, output int lat);
        int c0;
        alu_result = addr; rt_data = wdata; rd_addr = rd;
        mem_w = st; mem_r = ld; mem2reg = m2r; reg_write = rw;
        c0 = cyc;
        stalls = 0;
        #1 stalls += int'(stall);
        step();
        for (int i = 0; i < ack_after; i++) begin
            stalls += int'(stall);
            chk("hold_we", dmem_bus.we, st);
            chk("hold_addr", dmem_bus.addr, addr);
            chk("hold_wdata", dmem_bus.wdata, wdata);
            step();
        end
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = rdata;
        #1 stalls += int'(stall);
        step();
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = '0;
        set_nop();
        lat = cyc - c0;
    endtask

    initial begin
        int stalls, lat, r1, r2;
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = '0;

        repeat (2) step();
        chk("rst_req", dmem_bus.req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_err", dmem_err, 0);
        rst_n = 1'b1;

        // ALU pass-through
        alu_result = 32'h1234; rd_addr = 5; reg_write = 1;
        #1 chk("alu_stall", stall, 0);
        step();
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", wb_rd_addr, 5);
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_rw", wb_reg_write, 1);
        set_nop();
        step();

        // Load with three wait cycles before ack
        run_mem(0, 1, 32'h40, 32'h0, 7, 1, 1, 3, 32'hDEADBEEF, stalls, lat);
        chk("ld_stalls", stalls, 4);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_rd", wb_rd_addr, 7);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_rw", wb_reg_write, 1);
        step();

        // Store, then store with both mem_r and mem_w set
        run_mem(1, 0, 32'h80, 32'hA5A5A5A5, 2, 0, 0, 2, 32'hFFFFFFFF, stalls, lat);
        chk("st_stalls", stalls, 3);
        chk("st_wb_rw", wb_reg_write, 0);
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_data", wb_data, 32'h80);
        run_mem(1, 1, 32'h84, 32'h5A5A5A5A, 3, 0, 0, 1, 32'h0, stalls, lat);
        chk("st2_wb_rw", wb_reg_write, 0);
        step();

        // Asynchronous reset during WAIT
        alu_result = 32'h300; mem_r = 1; mem2reg = 1; reg_write = 1; rd_addr = 8;
        step();
        step();
        chk("pre_rst_req", dmem_bus.req, 1);
        set_nop();
        rst_n = 1'b0;
        #1;
        chk("arst_req", dmem_bus.req, 0);
        chk("arst_addr", dmem_bus.addr, 0);
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_wb_data", wb_data, 0);
        step();
        rst_n = 1'b1;
        alu_result = 32'hCAFE; rd_addr = 9; reg_write = 1;
        step();
        chk("post_rst_data", wb_data, 32'hCAFE);
        chk("post_rst_valid", wb_valid, 1);
        chk("post_rst_req", dmem_bus.req, 0);
        set_nop();

        // Spurious ack in IDLE
        alu_result = 32'h55; rd_addr = 3; reg_write = 1;
        dmem_bus.ack = 1'b1;
        step();
        dmem_bus.ack = 1'b0;
        chk("spur_req", dmem_bus.req, 0);
        chk("spur_wb_data", wb_data, 32'h55);
        chk("spur_wb_valid", wb_valid, 1);

        // Back-to-back loads with immediate ack
        run_mem(0, 1, 32'h100, 32'h0, 10, 1, 1, 0, 32'h11111111, stalls, lat);
        r1 = cyc;
        chk("b2b1_lat", lat, 2);
        chk("b2b1_stalls", stalls, 1);
        chk("b2b1_data", wb_data, 32'h11111111);
        run_mem(0, 1, 32'h104, 32'h0, 11, 1, 1, 0, 32'h22222222, stalls, lat);
        r2 = cyc;
        chk("b2b2_lat", lat, 2);
        chk("b2b_spacing", r2 - r1, 2);
        chk("b2b2_data", wb_data, 32'h22222222);
        chk("b2b2_rd", wb_rd_addr, 11);
        step();

`ifdef DMEM_TIMEOUT_EN
        // Ack on the last permitted wait cycle wins over the timeout
        run_mem(0, 1, 32'h180, 32'h0, 12, 1, 1, TIMEOUT - 1, 32'h33333333, stalls, lat);
        chk("to_ack_err", dmem_err, 0);
        chk("to_ack_data", wb_data, 32'h33333333);
        chk("to_ack_rw", wb_reg_write, 1);

        // No ack: abort after TIMEOUT wait cycles
        alu_result = 32'h200; mem_r = 1; mem2reg = 1; reg_write = 1; rd_addr = 4;
        #1 chk("to_idle_stall", stall, 1);
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            chk("to_wait_stall", stall, 1);
            chk("to_wait_req", dmem_bus.req, 1);
            step();
        end
        chk("to_abort_stall", stall, 0);
        step();
        chk("to_req", dmem_bus.req, 0);
        chk("to_err", dmem_err, 1);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_rw", wb_reg_write, 0);
        set_nop();
        step();
        step();
        chk("to_err_sticky", dmem_err, 1);
`endif

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
